fp_shift_pipe: RTL
==================

Name: fp_shift_pipe

Overview:
- Parametrised, two-stage pipelined mantissa shifter for the floating-point datapath.
- Serves both operand alignment (right shift with sticky) and post-add normalisation (left shift, or automatic left shift by leading-zero count).
- Output is a truncated window plus a sticky bit for the rounding unit.
- valid/ready handshake on both sides; sits between the exponent-difference logic and the adder/rounder.

Parameters:
- WIDTH, 64: internal mantissa width in bits.
- OUT_W, 27: output window width; window = result[WIDTH-1 : WIDTH-OUT_W]. Must satisfy OUT_W <= WIDTH.
- SHAMT_W, 8: shift-amount width. Must satisfy 2**SHAMT_W > WIDTH.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept an input beat this cycle.
- in_data  in  WIDTH  mantissa to shift.
- in_shamt  in  SHAMT_W  requested shift amount (ignored in NORM mode).
- in_mode  in  2  00 RIGHT, 01 LEFT, 10 NORM, 11 PASS.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  OUT_W  shifted window.
- out_sticky  out  1  OR of every 1 bit not present in out_data.
- out_shamt  out  SHAMT_W  shift actually applied.
- out_zero  out  1  in_data was all zeros.

Behaviour:
- Reset (synchronous): s1_valid = 0, s2_valid = 0. On the next cycle out_valid = 0 and in_ready = 1. out_data, out_sticky, out_shamt and out_zero reset to 0.
- Handshake:
  - Input transfer happens on in_valid & in_ready. Output transfer happens on out_valid & out_ready.
  - While out_valid is high and out_ready is low, out_* holds stable.
  - s2_en = ~s2_valid | out_ready.
  - in_ready = ~s1_valid | s2_en, derived combinationally from state and out_ready only, never from in_valid.
  - Bubbles collapse. Throughput is 1 beat per cycle when out_ready is held high.
- Latency: an accepted beat appears on out_valid exactly 2 cycles later when there is no backpressure.
- Stage 1 (registers data, mode and effective amount amt):
  - RIGHT/LEFT: amt = min(in_shamt, WIDTH).
  - NORM: amt = leading-zero count of in_data. If in_data == 0, amt = 0.
  - PASS: amt = 0.
  - zero flag = (in_data == 0), computed in all modes.
- Stage 2 (registers outputs):
  - RIGHT: res = data >> amt; lost = OR of data[amt-1:0]; when amt = WIDTH, res = 0 and lost = |data.
  - LEFT and NORM: res = data << amt; bits shifted out of the MSB are discarded and do not feed sticky.
  - PASS: res = data.
  - out_data = res[WIDTH-1 -: OUT_W].
  - out_sticky = lost | (|res[WIDTH-OUT_W-1:0]). When OUT_W == WIDTH, the second term is 0.
  - out_shamt = amt. out_zero = zero flag.
- Boundaries:
  - amt = 0: no shift and no lost bits.
  - Any in_shamt > WIDTH saturates to WIDTH.
  - NORM on zero input: out_data = 0, out_sticky = 0, out_zero = 1.
  - Simultaneous output transfer and input acceptance while both stages are full is legal; no beat is dropped or duplicated.
- Reset mid-operation: all in-flight beats are discarded with no partial output.

Decomposition:
- Package fp_shift_pkg holds the mode localparams MODE_RIGHT, MODE_LEFT, MODE_NORM, MODE_PASS and a clog2 helper function.
- One sub-module: leading_zero_counter, parametrised on WIDTH, outputting the count and an all_zero flag. Reused later by the normaliser.

Test Plan:
- Config: WIDTH=64, OUT_W=27.
- RIGHT, in_data=64'h8000_0000_0000_0001, shamt=1 -> out_data=27'h2000000, out_sticky=1, out_shamt=1, out_zero=0, 2 cycles after accept.
- LEFT, in_data=64'h1, shamt=63 -> out_data=27'h4000000, out_sticky=0, out_shamt=63.
- NORM, in_data=64'hF0 -> out_shamt=56, out_data=27'h7800000, out_sticky=0.
- NORM, in_data=0 -> out_zero=1, out_data=0, out_shamt=0.
- RIGHT, in_data=64'h1, shamt=200 -> out_data=0, out_sticky=1, out_shamt=64.
- Backpressure: hold out_ready=0 and offer 3 beats (RIGHT, shamt 0/1/2) -> exactly 2 beats accepted and in_ready falls. Then raise out_ready -> all 3 beats emerge in order with correct values and out_* stable while stalled.
- Reset mid-operation: assert reset for 1 cycle with both stages valid -> next cycle out_valid=0 and in_ready=1, and no stale beat is emitted afterwards.

Source files
------------

// File: rtl/fp_shift_pkg.sv
// Shared definitions for the floating-point mantissa shifter: shift-mode
// encodings and a constant ceil(log2) helper for sizing counters.
package fp_shift_pkg;

  localparam logic [1:0] MODE_RIGHT = 2'b00;
  localparam logic [1:0] MODE_LEFT  = 2'b01;
  localparam logic [1:0] MODE_NORM  = 2'b10;
  localparam logic [1:0] MODE_PASS  = 2'b11;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/fp_shift_pipe_lzc.sv
// Leading-zero counter: number of zero bits above the most significant set bit.
// An all-zero input reports WIDTH and raises all_zero_o.
module leading_zero_counter
  import fp_shift_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CNT_W = clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] data_i,
  output logic [CNT_W-1:0] count_o,
  output logic             all_zero_o
);

  // Ascending scan so the highest set bit is the last one to assign the count.
  always_comb begin
    count_o = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (data_i[i]) count_o = CNT_W'(WIDTH - 1 - i);
    end
  end

  assign all_zero_o = ~|data_i;

endmodule

// File: rtl/fp_shift_pipe.sv
// Two-stage mantissa shifter: stage 1 resolves the effective shift amount,
// stage 2 shifts, truncates to the output window and folds lost bits into sticky.
module fp_shift_pipe
  import fp_shift_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int OUT_W   = 27,
  parameter int SHAMT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic               out_sticky,
  output logic [SHAMT_W-1:0] out_shamt,
  output logic               out_zero
);

  localparam int CNT_W = clog2(WIDTH + 1);
  localparam logic [SHAMT_W-1:0] AMT_MAX = SHAMT_W'(WIDTH);

  logic               s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]   s1_data_q, s1_data_d;
  logic [1:0]         s1_mode_q, s1_mode_d;
  logic [SHAMT_W-1:0] s1_amt_q, s1_amt_d;
  logic               s1_zero_q, s1_zero_d;

  logic               s2_valid_q, s2_valid_d;
  logic [OUT_W-1:0]   out_data_q, out_data_d;
  logic               out_sticky_q, out_sticky_d;
  logic [SHAMT_W-1:0] out_shamt_q, out_shamt_d;
  logic               out_zero_q, out_zero_d;

  logic               s1_en, s2_en;
  logic [CNT_W-1:0]   lz_count;
  logic               lz_zero;
  logic [SHAMT_W-1:0] amt_in;
  logic [WIDTH-1:0]   res;
  logic               lost;
  logic               tail;

  leading_zero_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_lzc (
    .data_i     (in_data),
    .count_o    (lz_count),
    .all_zero_o (lz_zero)
  );

  // A stage may load whenever it is empty or its contents move on this cycle.
  assign s2_en    = ~s2_valid_q | out_ready;
  assign s1_en    = ~s1_valid_q | s2_en;
  assign in_ready = s1_en;

  always_comb begin
    amt_in = '0;
    case (in_mode)
      MODE_RIGHT, MODE_LEFT: amt_in = (in_shamt > AMT_MAX) ? AMT_MAX : in_shamt;
      MODE_NORM:             amt_in = lz_zero ? '0 : SHAMT_W'(lz_count);
      default:               amt_in = '0;
    endcase
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_mode_d  = s1_mode_q;
    s1_amt_d   = s1_amt_q;
    s1_zero_d  = s1_zero_q;
    if (s1_en) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_data_d = in_data;
        s1_mode_d = in_mode;
        s1_amt_d  = amt_in;
        s1_zero_d = lz_zero;
      end
    end
  end

  // Shifting by WIDTH yields zero, so amt == WIDTH needs no special case.
  always_comb begin
    res  = s1_data_q;
    lost = 1'b0;
    case (s1_mode_q)
      MODE_RIGHT: begin
        res  = s1_data_q >> s1_amt_q;
        lost = |(s1_data_q & ~({WIDTH{1'b1}} << s1_amt_q));
      end
      MODE_LEFT, MODE_NORM: res = s1_data_q << s1_amt_q;
      default:              res = s1_data_q;
    endcase
  end

  if (OUT_W < WIDTH) begin : g_tail
    assign tail = |res[WIDTH-OUT_W-1:0];
  end else begin : g_no_tail
    assign tail = 1'b0;
  end

  always_comb begin
    s2_valid_d   = s2_valid_q;
    out_data_d   = out_data_q;
    out_sticky_d = out_sticky_q;
    out_shamt_d  = out_shamt_q;
    out_zero_d   = out_zero_q;
    if (s2_en) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d   = res[WIDTH-1 -: OUT_W];
        out_sticky_d = lost | tail;
        out_shamt_d  = s1_amt_q;
        out_zero_d   = s1_zero_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q   <= 1'b0;
      s1_data_q    <= '0;
      s1_mode_q    <= MODE_RIGHT;
      s1_amt_q     <= '0;
      s1_zero_q    <= 1'b0;
      s2_valid_q   <= 1'b0;
      out_data_q   <= '0;
      out_sticky_q <= 1'b0;
      out_shamt_q  <= '0;
      out_zero_q   <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_data_q    <= s1_data_d;
      s1_mode_q    <= s1_mode_d;
      s1_amt_q     <= s1_amt_d;
      s1_zero_q    <= s1_zero_d;
      s2_valid_q   <= s2_valid_d;
      out_data_q   <= out_data_d;
      out_sticky_q <= out_sticky_d;
      out_shamt_q  <= out_shamt_d;
      out_zero_q   <= out_zero_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_data   = out_data_q;
  assign out_sticky = out_sticky_q;
  assign out_shamt  = out_shamt_q;
  assign out_zero   = out_zero_q;

endmodule
